xbar_master_port: RTL and testbench

- Upstream neighbour of the 2-input crossbar arbiter: one instance per master (port 0 drives req0/consumes grant0, port 1 drives req1/consumes grant1).
- Buffers master commands in a small FIFO and raises a request toward the arbiter.
- Issues one command per granted cycle onto the shared slave bus.
- Tracks outstanding reads and returns read responses to the master.

---
 rtl/xbar_pkg.sv | 19 +
 rtl/xbar_master_port_if.sv | 53 +++++
 rtl/xbar_cmd_fifo.sv | 56 +++++
 rtl/xbar_master_port.sv | 105 ++++++++++
 tb/tb_xbar_master_port.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xbar_pkg.sv
// Shared defaults and command type for the 2-master crossbar port blocks.
// Used by both the master-side port and any slave-side reuse of the command FIFO.
package xbar_pkg;

    localparam int DEF_AW      = 8;
    localparam int DEF_DW      = 16;
    localparam int NUM_MASTERS = 2;

    typedef struct packed {
        logic              we;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] wdata;
    } cmd_t;

    function automatic int cmd_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/xbar_master_port_if.sv
// Signal bundle between a master, the arbiter, the shared slave bus and one xbar_master_port.
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready are both high;
// bus_valid, rsp_valid and rd_valid are single-cycle qualifiers with no back-pressure.
interface xbar_master_port_if
    import xbar_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int MAX_RD = 3
);

    localparam int PW = $clog2(MAX_RD + 1);

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    logic          req;
    logic          grant;

    logic          bus_valid;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;

    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [PW-1:0] rd_pending;
    logic          err_rsp;

    // master: the port block itself; slave: the environment around it.
    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  grant, rsp_valid, rsp_rdata,
        output cmd_ready, req,
        output bus_valid, bus_we, bus_addr, bus_wdata,
        output rd_valid, rd_data, rd_pending, err_rsp
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output grant, rsp_valid, rsp_rdata,
        input  cmd_ready, req,
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        input  rd_valid, rd_data, rd_pending, err_rsp
    );

endinterface

// File: rtl/xbar_cmd_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; shared by master and slave ports.
// A push while full is only taken when a pop happens in the same cycle.
module xbar_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 25
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/xbar_master_port.sv
// Master-side crossbar port: queues commands, requests the registered arbiter, issues one
// command per useful grant and tracks outstanding reads so responses return in order.
module xbar_master_port
    import xbar_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int DEPTH  = 4,
    parameter int MAX_RD = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xbar_master_port_if.master   pif
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int PW    = $clog2(MAX_RD + 1);
    localparam int CMD_W = cmd_width(AW, DW);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_RD);

    logic [CMD_W-1:0] head_raw;
    logic             head_we;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_wdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;

    logic [PW-1:0]    pend;
    logic             err_q;
    logic             rd_valid_q;
    logic [DW-1:0]    rd_data_q;

    logic             below_limit;
    logic             head_ok;
    logic             req_ok;
    logic             issue;
    logic             rd_issue;
    logic             accept;

    assign accept = pif.cmd_valid & ~fifo_full;

    xbar_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   ({pif.cmd_we, pif.cmd_addr, pif.cmd_wdata}),
        .pop   (issue),
        .dout  (head_raw),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_we, head_addr, head_wdata} = head_raw;

    // cmd_ready comes only from the registered count, never from grant.
    assign pif.cmd_ready = ~fifo_full;

    assign below_limit = (pend < PEND_MAX);
    assign head_ok     = ~fifo_empty & (head_we | below_limit);
    assign issue       = pif.grant & head_ok;
    assign rd_issue    = issue & ~head_we;

    // A retiring response frees a read slot by the time the resulting grant arrives.
    assign req_ok  = ~fifo_empty & (head_we | below_limit | pif.rsp_valid);
    assign pif.req = req_ok & ((fifo_count >= CW'(2)) |
                               ((fifo_count == CW'(1)) & ~pif.grant));

    assign pif.bus_valid = issue;
    assign pif.bus_we    = issue ? head_we    : 1'b0;
    assign pif.bus_addr  = issue ? head_addr  : '0;
    assign pif.bus_wdata = issue ? head_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= pif.rsp_valid;
            if (pif.rsp_valid) begin
                rd_data_q <= pif.rsp_rdata;
            end
            if (pif.rsp_valid && pend == '0 && !rd_issue) begin
                err_q <= 1'b1;
            end
            case ({rd_issue, pif.rsp_valid})
                2'b10: if (below_limit) pend <= pend + PW'(1);
                2'b01: if (pend != '0)  pend <= pend - PW'(1);
                default: pend <= pend;
            endcase
        end
    end

    assign pif.rd_valid   = rd_valid_q;
    assign pif.rd_data    = rd_data_q;
    assign pif.rd_pending = pend;
    assign pif.err_rsp    = err_q;

endmodule

// File: tb/tb_xbar_master_port.sv
// Bench for xbar_master_port: directed scenarios plus random traffic against a
// queue-based reference of command order, outstanding reads and response forwarding.
module tb_xbar_master_port;
    import xbar_pkg::*;

    localparam int AW     = DEF_AW;
    localparam int DW     = DEF_DW;
    localparam int DEPTH  = 4;
    localparam int MAX_RD = 3;
    localparam int PW     = $clog2(MAX_RD + 1);
    localparam int CMD_W  = 1 + AW + DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic             auto_grant = 1'b0;
    logic             last_req   = 1'b0;
    logic [CMD_W-1:0] exp_q[$];
    int               pend_m = 0;
    logic             err_m  = 1'b0;
    logic             rdv_m  = 1'b0;
    logic [DW-1:0]    rdd_m  = '0;

    xbar_master_port_if #(.AW(AW), .DW(DW), .MAX_RD(MAX_RD)) pif();

    xbar_master_port #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_RD(MAX_RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif)
    );

    always #5 clk = ~clk;

    // Registered arbiter stand-in: grant is last cycle's req.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_grant) pif.grant = last_req;
        end
    end

    // Scoreboard: expected issue order, outstanding reads, error flag and response echo.
    always @(negedge clk) begin
        int       size0;
        cmd_t     head;
        logic     exp_issue, exp_req, rd_iss, issuable;
        if (!rst_n) begin
            exp_q.delete();
            pend_m = 0; err_m = 1'b0; rdv_m = 1'b0; rdd_m = '0; last_req = 1'b0;
            checks++;
            if ({pif.req, pif.bus_valid, pif.rd_valid, pif.err_rsp, pif.rd_pending,
                 pif.bus_we, pif.bus_addr, pif.bus_wdata, pif.rd_data} !== '0) begin
                errors++;
                $display("FAIL sb_reset_outputs: got req=%0b bus_valid=%0b rd_valid=%0b err=%0b pend=%0d, required all zero",
                         pif.req, pif.bus_valid, pif.rd_valid, pif.err_rsp, pif.rd_pending);
            end
        end else begin
            size0 = exp_q.size();
            head = (size0 > 0) ? cmd_t'(exp_q[0]) : cmd_t'('0);
            exp_issue = pif.grant && size0 > 0 && (head.we || pend_m < MAX_RD);
            issuable  = size0 > 0 && (head.we || pend_m < MAX_RD || pif.rsp_valid);
            exp_req   = issuable && (size0 >= 2 || (size0 == 1 && !pif.grant));
            rd_iss    = exp_issue && !head.we;

            checks++;
            if (pif.bus_valid !== exp_issue) begin
                errors++;
                $display("FAIL sb_bus_valid: got %0b required %0b at %0t", pif.bus_valid, exp_issue, $time);
            end
            checks++;
            if ({pif.bus_we, pif.bus_addr, pif.bus_wdata} !== (exp_issue ? CMD_W'(head) : CMD_W'(0))) begin
                errors++;
                $display("FAIL sb_bus_cmd: got we=%0b addr=%h data=%h required %h at %0t",
                         pif.bus_we, pif.bus_addr, pif.bus_wdata, exp_issue ? CMD_W'(head) : CMD_W'(0), $time);
            end
            checks++;
            if (pif.req !== exp_req) begin
                errors++;
                $display("FAIL sb_req: got %0b required %0b at %0t", pif.req, exp_req, $time);
            end
            checks++;
            if (pif.cmd_ready !== (size0 < DEPTH)) begin
                errors++;
                $display("FAIL sb_cmd_ready: got %0b required %0b at %0t", pif.cmd_ready, size0 < DEPTH, $time);
            end
            checks++;
            if (pif.rd_valid !== rdv_m || (rdv_m && pif.rd_data !== rdd_m)) begin
                errors++;
                $display("FAIL sb_rd: got valid=%0b data=%h required valid=%0b data=%h at %0t",
                         pif.rd_valid, pif.rd_data, rdv_m, rdd_m, $time);
            end
            checks++;
            if (pif.rd_pending !== PW'(pend_m) || pif.err_rsp !== err_m) begin
                errors++;
                $display("FAIL sb_pend_err: got pend=%0d err=%0b required pend=%0d err=%0b at %0t",
                         pif.rd_pending, pif.err_rsp, pend_m, err_m, $time);
            end

            if (exp_issue) void'(exp_q.pop_front());
            if (pif.rsp_valid && pend_m == 0 && !rd_iss) err_m = 1'b1;
            if (rd_iss && !pif.rsp_valid && pend_m < MAX_RD) pend_m++;
            else if (pif.rsp_valid && !rd_iss && pend_m > 0) pend_m--;
            rdv_m = pif.rsp_valid;
            if (pif.rsp_valid) rdd_m = pif.rsp_rdata;
            if (pif.cmd_valid && size0 < DEPTH)
                exp_q.push_back({pif.cmd_we, pif.cmd_addr, pif.cmd_wdata});
            last_req = pif.req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   n;
        logic acc;
        n = 0;
        acc = 1'b0;
        pif.cmd_valid = 1'b1; pif.cmd_we = we; pif.cmd_addr = a; pif.cmd_wdata = d;
        while (!acc) begin
            @(negedge clk);
            acc = pif.cmd_ready;
            tick();
            n++;
            if (!acc && n > 50) begin
                checks++; errors++;
                $display("FAIL push_timeout: cmd_ready stayed %0b, required 1 within 50 cycles", pif.cmd_ready);
                acc = 1'b1;
            end
        end
        pif.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (pif.cmd_ready !== 1'b1 || pif.req !== 1'b0 || pif.bus_valid !== 1'b0 ||
            pif.rd_pending !== '0 || pif.err_rsp !== 1'b0 || pif.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%0b req=%0b bus_valid=%0b pend=%0d err=%0b rd_valid=%0b required 1,0,0,0,0,0",
                     pif.cmd_ready, pif.req, pif.bus_valid, pif.rd_pending, pif.err_rsp, pif.rd_valid);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        tick();
        auto_grant = 1'b1;
        push_cmd(1'b1, 8'h10, 16'hBEEF);
        @(negedge clk);
        checks++;
        if (pif.req !== 1'b1 || pif.bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_req: got req=%0b bus_valid=%0b required 1,0", pif.req, pif.bus_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pif.bus_valid !== 1'b1 || pif.bus_we !== 1'b1 || pif.bus_addr !== 8'h10 || pif.bus_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL single_issue: got valid=%0b we=%0b addr=%h data=%h required 1,1,10,beef",
                     pif.bus_valid, pif.bus_we, pif.bus_addr, pif.bus_wdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pif.bus_valid !== 1'b0 || pif.req !== 1'b0 || pif.rd_pending !== '0 || pif.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_idle: got valid=%0b req=%0b pend=%0d ready=%0b required 0,0,0,1",
                     pif.bus_valid, pif.req, pif.rd_pending, pif.cmd_ready);
        end
        auto_grant = 1'b0;
        pif.grant = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d [4];
        tick();
        pif.grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d[i] = DW'($urandom);
            push_cmd(1'b1, AW'(8'h50 + i), d[i]);
        end
        @(negedge clk);
        checks++;
        if (pif.cmd_ready !== 1'b0 || pif.req !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full: got ready=%0b req=%0b required 0,1", pif.cmd_ready, pif.req);
        end
        tick();
        pif.grant = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pif.bus_valid !== 1'b1 || pif.bus_addr !== AW'(8'h50 + i) || pif.bus_wdata !== d[i] ||
                pif.req !== (i < 3)) begin
                errors++;
                $display("FAIL b2b_issue%0d: got valid=%0b addr=%h data=%h req=%0b required 1,%h,%h,%0b",
                         i, pif.bus_valid, pif.bus_addr, pif.bus_wdata, pif.req, AW'(8'h50 + i), d[i], i < 3);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (pif.bus_valid !== 1'b0 || pif.req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stale: got valid=%0b req=%0b required 0,0", pif.bus_valid, pif.req);
        end
        tick();
        pif.grant = 1'b0;
    endtask

    task automatic test_read_limit();
        tick();
        auto_grant = 1'b1;
        for (int i = 0; i < 4; i++) push_cmd(1'b0, AW'(8'h20 + i), '0);
        repeat (6) tick();
        @(negedge clk);
        checks++;
        if (pif.rd_pending !== PW'(3) || pif.req !== 1'b0 || pif.bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdlim_block: got pend=%0d req=%0b valid=%0b required 3,0,0",
                     pif.rd_pending, pif.req, pif.bus_valid);
        end
        tick();
        pif.rsp_valid = 1'b1;
        pif.rsp_rdata = 16'h1234;
        @(negedge clk);
        checks++;
        if (pif.req !== 1'b1) begin
            errors++;
            $display("FAIL rdlim_req_on_rsp: got req=%0b required 1", pif.req);
        end
        tick();
        pif.rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pif.rd_valid !== 1'b1 || pif.rd_data !== 16'h1234 || pif.bus_valid !== 1'b1 ||
            pif.bus_we !== 1'b0 || pif.bus_addr !== 8'h23) begin
            errors++;
            $display("FAIL rdlim_fourth: got rd_valid=%0b rd_data=%h valid=%0b we=%0b addr=%h required 1,1234,1,0,23",
                     pif.rd_valid, pif.rd_data, pif.bus_valid, pif.bus_we, pif.bus_addr);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pif.rd_pending !== PW'(3)) begin
            errors++;
            $display("FAIL rdlim_pend_back: got %0d required 3", pif.rd_pending);
        end
        repeat (3) begin
            tick();
            pif.rsp_valid = 1'b1;
            pif.rsp_rdata = DW'($urandom);
        end
        tick();
        pif.rsp_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (pif.rd_pending !== '0) begin
            errors++;
            $display("FAIL rdlim_drain: got pend=%0d required 0", pif.rd_pending);
        end
        auto_grant = 1'b0;
        pif.grant = 1'b0;
    endtask

    task automatic test_alternating_grant();
        logic g;
        tick();
        pif.grant = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(1'b1, AW'(8'h60 + i), DW'($urandom));
        for (int k = 0; k < 6; k++) begin
            g = (k % 2 == 0);
            pif.grant = g;
            @(negedge clk);
            checks++;
            if (pif.bus_valid !== g || (g && pif.bus_addr !== AW'(8'h60 + k / 2))) begin
                errors++;
                $display("FAIL alt_slot%0d: got valid=%0b addr=%h required %0b,%h",
                         k, pif.bus_valid, pif.bus_addr, g, AW'(8'h60 + k / 2));
            end
            tick();
        end
        pif.grant = 1'b0;
        @(negedge clk);
        checks++;
        if (pif.req !== 1'b0 || pif.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL alt_empty: got req=%0b ready=%0b required 0,1", pif.req, pif.cmd_ready);
        end
    endtask

    task automatic test_simultaneous();
        tick();
        pif.grant = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(1'b0, AW'(8'h70 + i), '0);
        pif.grant = 1'b1;
        tick();
        tick();
        pif.grant = 1'b0;
        @(negedge clk);
        checks++;
        if (pif.rd_pending !== PW'(2)) begin
            errors++;
            $display("FAIL simul_setup: got pend=%0d required 2", pif.rd_pending);
        end
        tick();
        pif.grant = 1'b1;
        pif.rsp_valid = 1'b1;
        pif.rsp_rdata = 16'hCAFE;
        @(negedge clk);
        checks++;
        if (pif.bus_valid !== 1'b1 || pif.bus_we !== 1'b0 || pif.bus_addr !== 8'h72) begin
            errors++;
            $display("FAIL simul_issue: got valid=%0b we=%0b addr=%h required 1,0,72",
                     pif.bus_valid, pif.bus_we, pif.bus_addr);
        end
        tick();
        pif.grant = 1'b0;
        pif.rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pif.rd_pending !== PW'(2) || pif.rd_valid !== 1'b1 || pif.rd_data !== 16'hCAFE) begin
            errors++;
            $display("FAIL simul_pend: got pend=%0d rd_valid=%0b rd_data=%h required 2,1,cafe",
                     pif.rd_pending, pif.rd_valid, pif.rd_data);
        end
        repeat (2) begin
            tick();
            pif.rsp_valid = 1'b1;
            pif.rsp_rdata = DW'($urandom);
        end
        tick();
        pif.rsp_valid = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (pif.rd_pending !== '0 || pif.err_rsp !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: got pend=%0d err=%0b required 0,0", pif.rd_pending, pif.err_rsp);
        end
    endtask

    task automatic test_spurious_and_reset();
        tick();
        pif.rsp_valid = 1'b1;
        pif.rsp_rdata = 16'hA5A5;
        tick();
        pif.rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pif.err_rsp !== 1'b1 || pif.rd_valid !== 1'b1 || pif.rd_data !== 16'hA5A5 || pif.rd_pending !== '0) begin
            errors++;
            $display("FAIL spur_flag: got err=%0b rd_valid=%0b rd_data=%h pend=%0d required 1,1,a5a5,0",
                     pif.err_rsp, pif.rd_valid, pif.rd_data, pif.rd_pending);
        end
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (pif.err_rsp !== 1'b1) begin
            errors++;
            $display("FAIL spur_sticky: got err=%0b required 1", pif.err_rsp);
        end
        tick();
        pif.grant = 1'b0;
        push_cmd(1'b0, 8'h40, '0);
        push_cmd(1'b1, 8'h41, 16'h4141);
        pif.grant = 1'b1;
        #1;
        checks++;
        if (pif.bus_valid !== 1'b1 || pif.bus_we !== 1'b0) begin
            errors++;
            $display("FAIL burst_read: got valid=%0b we=%0b required 1,0", pif.bus_valid, pif.bus_we);
        end
        tick();
        #1;
        checks++;
        if (pif.bus_valid !== 1'b1 || pif.bus_we !== 1'b1) begin
            errors++;
            $display("FAIL burst_write: got valid=%0b we=%0b required 1,1", pif.bus_valid, pif.bus_we);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pif.req !== 1'b0 || pif.bus_valid !== 1'b0 || pif.rd_pending !== '0 || pif.err_rsp !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got req=%0b valid=%0b pend=%0d err=%0b required 0,0,0,0",
                     pif.req, pif.bus_valid, pif.rd_pending, pif.err_rsp);
        end
        pif.grant = 1'b0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        pif.rsp_valid = 1'b1;
        pif.rsp_rdata = 16'h0404;
        tick();
        pif.rsp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (pif.err_rsp !== 1'b1 || pif.rd_valid !== 1'b1 || pif.rd_data !== 16'h0404) begin
            errors++;
            $display("FAIL stale_rsp: got err=%0b rd_valid=%0b rd_data=%h required 1,1,0404",
                     pif.err_rsp, pif.rd_valid, pif.rd_data);
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (pif.err_rsp !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got err=%0b required 0", pif.err_rsp);
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int n;
        tick();
        for (int phase = 0; phase < 2; phase++) begin
            auto_grant = (phase == 0);
            pif.grant = 1'b0;
            for (int c = 0; c < 200; c++) begin
                pif.cmd_valid = ($urandom_range(0, 2) != 0);
                pif.cmd_we    = $urandom_range(0, 1) != 0;
                pif.cmd_addr  = AW'($urandom);
                pif.cmd_wdata = DW'($urandom);
                pif.rsp_valid = (pend_m > 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
                pif.rsp_rdata = DW'($urandom);
                if (phase == 1) pif.grant = ($urandom_range(0, 1) != 0);
                tick();
            end
        end
        pif.cmd_valid = 1'b0;
        pif.grant = 1'b0;
        auto_grant = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || pend_m != 0) && n < 300) begin
            pif.rsp_valid = (pend_m > 0) && ($urandom_range(0, 1) != 0);
            pif.rsp_rdata = DW'($urandom);
            tick();
            n++;
        end
        pif.rsp_valid = 1'b0;
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL rand_drain_timeout: got %0d queued, %0d pending after 300 cycles, required 0,0",
                     exp_q.size(), pend_m);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pif.rd_pending !== '0 || pif.cmd_ready !== 1'b1 || pif.bus_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_idle: got pend=%0d ready=%0b valid=%0b required 0,1,0",
                     pif.rd_pending, pif.cmd_ready, pif.bus_valid);
        end
        auto_grant = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        pif.cmd_valid = 1'b0;
        pif.cmd_we    = 1'b0;
        pif.cmd_addr  = '0;
        pif.cmd_wdata = '0;
        pif.grant     = 1'b0;
        pif.rsp_valid = 1'b0;
        pif.rsp_rdata = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_limit();
        test_alternating_grant();
        test_simultaneous();
        test_spurious_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
